ballot_cast_unit: RTL and testbench

- Voter-side front end that drives the vote_a/vote_b/vote_c inputs of the secure voting machine.
- A polling officer issues one ballot per voter with a token pulse. The voter's buttons are debounced, the voter selects one candidate and confirms, and the block then drives exactly one one-hot vote level until the machine acknowledges with busy.
- Enforces one vote per token, handles acknowledge timeout, and keeps issued/cast ballot counters for audit.

---
 rtl/ballot_cast_unit.sv | 196 +++++++++++++++++++
 tb/tb_ballot_cast_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ballot_cast_unit.sv
// Voter-side ballot front end: debounces the candidate/confirm buttons, enforces one vote per
// token, drives a single one-hot vote level until the machine acknowledges, and keeps audit counters.
module ballot_cast_unit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACK_TIMEOUT     = 16,
    parameter int COOLDOWN        = 8,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             voting_enabled,
    input  logic             busy,
    input  logic             voter_token,
    input  logic             btn_a,
    input  logic             btn_b,
    input  logic             btn_c,
    input  logic             confirm,
    output logic             vote_a,
    output logic             vote_b,
    output logic             vote_c,
    output logic             ready,
    output logic [1:0]       selection,
    output logic             cast_done,
    output logic             cast_error,
    output logic [CNT_W-1:0] ballots_issued,
    output logic [CNT_W-1:0] ballots_cast
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);
    localparam int TM_MAX = (ACK_TIMEOUT > COOLDOWN) ? ACK_TIMEOUT : COOLDOWN;
    localparam int TM_W = $clog2(TM_MAX + 1);
    localparam logic [TM_W-1:0] ACK_LAST  = TM_W'(ACK_TIMEOUT - 1);
    localparam logic [TM_W-1:0] COOL_LAST = TM_W'(COOLDOWN - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMED    = 3'd1,
        SELECTED = 3'd2,
        DRIVE    = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [3:0]        raw;
    logic [DB_W-1:0]   db_cnt [4];
    logic [3:0]        db_level, db_level_q, press;
    logic [2:0]        cand_press;
    logic              single_press;
    logic [1:0]        press_code;
    logic [1:0]        sel_n;
    logic [TM_W-1:0]   timer, timer_n;
    logic [2:0]        vote_q, vote_n;
    logic              done_n, err_n, inc_issued, inc_cast;

    // Bit order: a, b, c, confirm.
    assign raw = {confirm, btn_c, btn_b, btn_a};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
            db_level_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!raw[i])
                    db_cnt[i] <= '0;
                else if (db_cnt[i] != DB_MAX)
                    db_cnt[i] <= db_cnt[i] + 1'b1;
            end
            db_level_q <= db_level;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) db_level[i] = (db_cnt[i] == DB_MAX);
    end

    assign press        = db_level & ~db_level_q;
    assign cand_press   = press[2:0];
    assign single_press = (cand_press == 3'b001) || (cand_press == 3'b010) || (cand_press == 3'b100);

    always_comb begin
        press_code = 2'b11;
        case (cand_press)
            3'b001:  press_code = 2'b00;
            3'b010:  press_code = 2'b01;
            3'b100:  press_code = 2'b10;
            default: press_code = 2'b11;
        endcase
    end

    always_comb begin
        state_n    = state;
        sel_n      = selection;
        timer_n    = timer;
        vote_n     = 3'b000;
        done_n     = 1'b0;
        err_n      = 1'b0;
        inc_issued = 1'b0;
        inc_cast   = 1'b0;
        case (state)
            IDLE: begin
                if (voter_token && voting_enabled) begin
                    state_n    = ARMED;
                    sel_n      = 2'b11;
                    inc_issued = 1'b1;
                end
            end
            ARMED: begin
                if (!voting_enabled) begin
                    state_n = IDLE;
                    sel_n   = 2'b11;
                    err_n   = 1'b1;
                end else if (single_press) begin
                    state_n = SELECTED;
                    sel_n   = press_code;
                end
            end
            SELECTED: begin
                // A candidate press in the same cycle as confirm wins; the confirm is dropped.
                if (!voting_enabled) begin
                    state_n = IDLE;
                    sel_n   = 2'b11;
                    err_n   = 1'b1;
                end else if (single_press) begin
                    sel_n = press_code;
                end else if (cand_press == 3'b000 && press[3]) begin
                    state_n = DRIVE;
                    timer_n = '0;
                end
            end
            DRIVE: begin
                if (busy) begin
                    state_n  = RELEASE;
                    timer_n  = '0;
                    done_n   = 1'b1;
                    inc_cast = 1'b1;
                end else if (timer == ACK_LAST) begin
                    state_n = RELEASE;
                    timer_n = '0;
                    err_n   = 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                    case (selection)
                        2'b00:   vote_n = 3'b001;
                        2'b01:   vote_n = 3'b010;
                        2'b10:   vote_n = 3'b100;
                        default: vote_n = 3'b000;
                    endcase
                end
            end
            RELEASE: begin
                if (timer == COOL_LAST) begin
                    state_n = IDLE;
                    sel_n   = 2'b11;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                sel_n   = 2'b11;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            selection      <= 2'b11;
            timer          <= '0;
            vote_q         <= 3'b000;
            cast_done      <= 1'b0;
            cast_error     <= 1'b0;
            ballots_issued <= '0;
            ballots_cast   <= '0;
        end else begin
            state      <= state_n;
            selection  <= sel_n;
            timer      <= timer_n;
            vote_q     <= vote_n;
            cast_done  <= done_n;
            cast_error <= err_n;
            if (inc_issued && ballots_issued != {CNT_W{1'b1}})
                ballots_issued <= ballots_issued + 1'b1;
            if (inc_cast && ballots_cast != {CNT_W{1'b1}})
                ballots_cast <= ballots_cast + 1'b1;
        end
    end

    assign vote_a = vote_q[0];
    assign vote_b = vote_q[1];
    assign vote_c = vote_q[2];
    assign ready  = (state == ARMED) || (state == SELECTED);

endmodule

// File: tb/tb_ballot_cast_unit.sv
// Bench for ballot_cast_unit: directed scenarios plus randomized ballots scored against a
// transaction-level model of selection, vote line, pulses and audit counters.
module tb_ballot_cast_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       voting_enabled, busy, voter_token;
    logic       btn_a, btn_b, btn_c, confirm;
    logic       vote_a, vote_b, vote_c, ready;
    logic [1:0] selection;
    logic       cast_done, cast_error;
    logic [7:0] ballots_issued, ballots_cast;

    int  checks = 0;
    int  errors = 0;
    int  exp_issued = 0;
    int  exp_cast = 0;
    int  exp_sel = 3;
    bit  saw_a = 0;

    ballot_cast_unit dut (
        .clk(clk), .reset(reset), .voting_enabled(voting_enabled), .busy(busy),
        .voter_token(voter_token), .btn_a(btn_a), .btn_b(btn_b), .btn_c(btn_c),
        .confirm(confirm), .vote_a(vote_a), .vote_b(vote_b), .vote_c(vote_c),
        .ready(ready), .selection(selection), .cast_done(cast_done),
        .cast_error(cast_error), .ballots_issued(ballots_issued), .ballots_cast(ballots_cast)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Invariant: never more than one vote line high.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("onehot_votes", 32'(int'(vote_a) + int'(vote_b) + int'(vote_c) <= 1), 1);
            if (vote_a) saw_a = 1;
        end
    end

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic logic [2:0] votes_for(input int sel);
        logic [2:0] one;
        one = 3'b001;
        return (sel < 3) ? (one << sel) : 3'b000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0: btn_a = v;
            1: btn_b = v;
            2: btn_c = v;
            default: confirm = v;
        endcase
    endtask

    // Hold a raw button high for len cycles, then give the FSM time to react.
    task automatic press(input int idx, input int len);
        set_btn(idx, 1'b1);
        repeat (len) step();
        set_btn(idx, 1'b0);
        repeat (2) step();
        if (idx < 3 && len >= 4 && exp_sel != 4) exp_sel = idx;
    endtask

    task automatic open_ballot();
        voter_token = 1'b1;
        step();
        voter_token = 1'b0;
        exp_issued = sat(exp_issued + 1);
        exp_sel = 3;
        check("open_ready", ready, 1);
        check("open_issued", ballots_issued, exp_issued);
        check("open_sel", selection, 3);
    endtask

    // Confirm, wait for the vote line, then either acknowledge after d cycles or let it time out.
    // Ends one cycle into RELEASE, then probes the cooldown with a dropped token.
    task automatic cast(input int conf_len, input bit ack, input int d);
        bit found;
        found = 0;
        confirm = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == conf_len - 1) confirm = 1'b0;
            if ({vote_c, vote_b, vote_a} != 3'b000) begin
                found = 1;
                break;
            end
        end
        confirm = 1'b0;
        check("vote_rise_seen", found, 1);
        check("vote_line", {vote_c, vote_b, vote_a}, votes_for(exp_sel));
        check("drive_ready", ready, 0);
        if (ack) begin
            repeat (d) step();
            check("vote_held", {vote_c, vote_b, vote_a}, votes_for(exp_sel));
            busy = 1'b1;
            step();
            busy = 1'b0;
            exp_cast = sat(exp_cast + 1);
            check("cast_done", cast_done, 1);
            check("cast_error_on_ack", cast_error, 0);
            check("vote_drop_ack", {vote_c, vote_b, vote_a}, 0);
            check("cast_count", ballots_cast, exp_cast);
            step();
            check("cast_done_pulse", cast_done, 0);
        end else begin
            repeat (14) step();
            check("vote_before_timeout", {vote_c, vote_b, vote_a}, votes_for(exp_sel));
            step();
            check("vote_drop_timeout", {vote_c, vote_b, vote_a}, 0);
            check("timeout_error", cast_error, 1);
            check("timeout_no_done", cast_done, 0);
            check("timeout_cast_count", ballots_cast, exp_cast);
            step();
            check("timeout_error_pulse", cast_error, 0);
        end
        for (int i = 0; i < 6; i++) begin
            check("cooldown_low", {vote_c, vote_b, vote_a}, 0);
            step();
        end
        voter_token = 1'b1;
        step();
        voter_token = 1'b0;
        check("release_token_dropped", ready, 0);
        check("release_token_issued", ballots_issued, exp_issued);
        exp_sel = 3;
        check("release_sel", selection, 3);
    endtask

    initial begin
        reset = 1'b1;
        voting_enabled = 1'b1;
        busy = 1'b0; voter_token = 1'b0;
        btn_a = 1'b0; btn_b = 1'b0; btn_c = 1'b0; confirm = 1'b0;
        repeat (3) step();
        check("rst_votes", {vote_c, vote_b, vote_a}, 0);
        check("rst_ready", ready, 0);
        check("rst_sel", selection, 3);
        check("rst_done", cast_done, 0);
        check("rst_error", cast_error, 0);
        check("rst_issued", ballots_issued, 0);
        check("rst_cast", ballots_cast, 0);
        reset = 1'b0;
        step();

        // Normal cast for candidate B, busy two cycles after vote_b rises.
        open_ballot();
        press(1, 6);
        check("normal_sel", selection, 1);
        cast(6, 1, 2);
        check("normal_issued", ballots_issued, 1);

        // Bounce, simultaneous press, confirm in ARMED, candidate+confirm together, then timeout.
        open_ballot();
        btn_a = 1'b1; repeat (3) step();
        btn_a = 1'b0; step();
        btn_a = 1'b1; repeat (3) step();
        btn_a = 1'b0; repeat (2) step();
        check("bounce_sel", selection, 3);
        check("bounce_ready", ready, 1);
        btn_a = 1'b1; btn_b = 1'b1; repeat (5) step();
        btn_a = 1'b0; btn_b = 1'b0; repeat (2) step();
        check("double_press_sel", selection, 3);
        press(3, 5);
        check("armed_confirm_ready", ready, 1);
        check("armed_confirm_votes", {vote_c, vote_b, vote_a}, 0);
        press(2, 5);
        check("select_c", selection, 2);
        btn_b = 1'b1; confirm = 1'b1; repeat (5) step();
        btn_b = 1'b0; confirm = 1'b0; repeat (2) step();
        exp_sel = 1;
        check("cand_confirm_sel", selection, 1);
        check("cand_confirm_ready", ready, 1);
        check("cand_confirm_votes", {vote_c, vote_b, vote_a}, 0);
        cast(5, 0, 0);

        // Reselect A then C; vote_a must never appear.
        open_ballot();
        saw_a = 0;
        press(0, 5);
        check("reselect_a", selection, 0);
        press(2, 5);
        check("reselect_c", selection, 2);
        cast(4, 1, 3);
        check("reselect_no_vote_a", saw_a, 0);

        // Token ignored while disabled, then void by disable in SELECTED.
        voting_enabled = 1'b0;
        voter_token = 1'b1; step(); voter_token = 1'b0; step();
        check("disabled_token_ready", ready, 0);
        check("disabled_token_issued", ballots_issued, exp_issued);
        voting_enabled = 1'b1;
        open_ballot();
        press(1, 4);
        check("void_pre_sel", selection, 1);
        voting_enabled = 1'b0;
        step();
        check("void_error", cast_error, 1);
        check("void_ready", ready, 0);
        check("void_sel", selection, 3);
        step();
        check("void_error_pulse", cast_error, 0);
        check("void_cast_count", ballots_cast, exp_cast);
        voting_enabled = 1'b1;

        // Randomized ballots.
        for (int n = 0; n < 16; n++) begin
            int np;
            open_ballot();
            np = $urandom_range(1, 3);
            for (int p = 0; p < np; p++) begin
                press($urandom_range(0, 2), $urandom_range(2, 7));
                check("rand_sel", selection, exp_sel);
                check("rand_ready", ready, 1);
            end
            if (exp_sel == 3) begin
                press($urandom_range(0, 2), 5);
                check("rand_sel_forced", selection, exp_sel);
            end
            cast($urandom_range(4, 6), ($urandom_range(0, 3) != 0), $urandom_range(2, 14));
        end

        // Asynchronous reset in the middle of DRIVE.
        open_ballot();
        press(0, 5);
        confirm = 1'b1;
        repeat (7) step();
        confirm = 1'b0;
        check("pre_reset_vote_a", {vote_c, vote_b, vote_a}, 3'b001);
        #2 reset = 1'b1;
        #1;
        check("async_reset_votes", {vote_c, vote_b, vote_a}, 0);
        check("async_reset_issued", ballots_issued, 0);
        check("async_reset_cast", ballots_cast, 0);
        check("async_reset_ready", ready, 0);
        check("async_reset_sel", selection, 3);
        step();
        reset = 1'b0;
        exp_issued = 0;
        exp_cast = 0;
        step();

        // Saturation: 256 accepted tokens, each voided to return to IDLE.
        for (int t = 0; t < 256; t++) begin
            voter_token = 1'b1;
            step();
            voter_token = 1'b0;
            voting_enabled = 1'b0;
            step();
            voting_enabled = 1'b1;
            exp_issued = sat(exp_issued + 1);
            if (t == 254) check("issued_at_255", ballots_issued, exp_issued);
        end
        step();
        check("issued_saturated", ballots_issued, exp_issued);
        check("cast_after_sat", ballots_cast, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
